// File: rtl/seq_arith_pkg.sv
// Shared opcodes and FSM state encoding for the sequential arithmetic unit.
package seq_arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_arith_step.sv
// One combinational iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
// hi/lo hold accumulator:multiplier for mul and remainder:quotient for div.
module seq_arith_step #(
    parameter int W = 16
) (
    input  logic         div_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] opnd_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [W:0] acc;
    logic [W:0] shifted;
    logic [W:0] trial;
    logic       ge;

    always_comb begin
        acc     = {1'b0, hi_i} + ({(W+1){lo_i[0]}} & {1'b0, opnd_i});
        shifted = {hi_i, lo_i[W-1]};
        trial   = shifted - {1'b0, opnd_i};
        ge      = shifted >= {1'b0, opnd_i};
        if (div_i) begin
            // remainder < divisor on entry, so the kept value always fits W bits
            hi_o = ge ? trial[W-1:0] : shifted[W-1:0];
            lo_o = {lo_i[W-2:0], ge};
        end else begin
            hi_o = acc[W:1];
            lo_o = {acc[0], lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential add/sub/mul/div unit with start/busy/done handshake; mul/div take W iterations.
// Define SIGNED_EN to honour op_signed for mul/div (magnitude datapath plus sign fix-up in FIN).
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         op_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result_lo,
    output logic [W-1:0] result_hi,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [W-1:0]    hi_q, lo_q, opnd_q;
    logic            negq_q, negr_q, dbz_pend_q;
    logic            busy_q, done_q, dbz_q;
    logic [W-1:0]    res_lo_q, res_hi_q;

    logic            sgn, a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W-1:0]    step_hi, step_lo;
    logic [W:0]      add_sum, sub_dif;
    logic [2*W-1:0]  prod, prod_s;
    logic [W-1:0]    quo, rem;
    logic [W-1:0]    fin_lo_d, fin_hi_d;

`ifdef SIGNED_EN
    assign sgn = op_signed & op[1];
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign sgn = 1'b0;
`endif

    assign a_neg = sgn & a[W-1];
    assign b_neg = sgn & b[W-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    seq_arith_step #(.W(W)) u_step (
        .div_i  (op_q[0]),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        add_sum = {1'b0, hi_q} + {1'b0, opnd_q};
        sub_dif = {1'b0, hi_q} - {1'b0, opnd_q};
        prod    = {hi_q, lo_q};
        prod_s  = negq_q ? -prod : prod;
        quo     = negq_q ? -lo_q : lo_q;
        rem     = negr_q ? -hi_q : hi_q;
        fin_lo_d = '0;
        fin_hi_d = '0;
        case (op_q)
            OP_ADD: begin
                fin_lo_d = add_sum[W-1:0];
                fin_hi_d = {{(W-1){1'b0}}, add_sum[W]};
            end
            OP_SUB: begin
                fin_lo_d = sub_dif[W-1:0];
                fin_hi_d = {{(W-1){1'b0}}, sub_dif[W]};
            end
            OP_MUL: {fin_hi_d, fin_lo_d} = prod_s;
            default: begin
                // divide-by-zero staged all-ones / raw dividend directly in lo/hi
                fin_lo_d = dbz_pend_q ? lo_q : quo;
                fin_hi_d = dbz_pend_q ? hi_q : rem;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_ADD;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        busy_q     <= 1'b1;
                        negq_q     <= a_neg ^ b_neg;
                        negr_q     <= a_neg;
                        cnt_q      <= CW'(W-1);
                        dbz_pend_q <= 1'b0;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                hi_q    <= a;
                                lo_q    <= '0;
                                opnd_q  <= b;
                                state_q <= FIN;
                            end
                            OP_MUL: begin
                                hi_q    <= '0;
                                lo_q    <= b_mag;
                                opnd_q  <= a_mag;
                                state_q <= RUN;
                            end
                            default: begin
                                if (b == '0) begin
                                    hi_q       <= a;
                                    lo_q       <= '1;
                                    opnd_q     <= b;
                                    dbz_pend_q <= 1'b1;
                                    state_q    <= FIN;
                                end else begin
                                    hi_q    <= '0;
                                    lo_q    <= a_mag;
                                    opnd_q  <= b_mag;
                                    state_q <= RUN;
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0)
                        state_q <= FIN;
                end
                FIN: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    dbz_q    <= dbz_pend_q;
                    res_lo_q <= fin_lo_d;
                    res_hi_q <= fin_hi_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Randomised self-checking bench for seq_arith_unit against a plain-arithmetic reference model.
module tb_seq_arith_unit;

    localparam int W = 16;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;
`ifdef SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic         clk, rst_n, start, op_signed;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    int n_chk = 0;
    int n_pass = 0;

    seq_arith_unit #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_signed(op_signed),
        .a(a), .b(b), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic sg, output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dz);
        longint ux, uy, sx, sy, r;
        bit use_s;
        use_s = SGN && sg && o[1];
        ux = longint'(x);
        uy = longint'(y);
        sx = use_s ? longint'($signed(x)) : ux;
        sy = use_s ? longint'($signed(y)) : uy;
        dz = 1'b0;
        lo = '0;
        hi = '0;
        case (o)
            ADD: begin r = ux + uy; lo = W'(r); hi = (r >= (64'sd1 <<< W)) ? W'(1) : W'(0); end
            SUB: begin lo = W'(ux - uy); hi = (ux < uy) ? W'(1) : W'(0); end
            MUL: begin r = sx * sy; lo = W'(r); hi = W'(r >>> W); end
            default: begin
                if (uy == 0) begin lo = '1; hi = x; dz = 1'b1; end
                else begin lo = W'(sx / sy); hi = W'(sx % sy); end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
        return (o == ADD || o == SUB || (o == DIV && y == '0)) ? 1 : W + 1;
    endfunction

    // Launch one op, scramble inputs after acceptance, return edges-to-done (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sg, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; op_signed = sg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 2'($urandom); op_signed = 1'($urandom);
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = ADD; op_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_chk++; if (result_lo !== '0) $display("FAIL reset_lo: got %h expected 0", result_lo); else n_pass++;
        n_chk++; if (result_hi !== '0) $display("FAIL reset_hi: got %h expected 0", result_hi); else n_pass++;
        n_chk++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", div_by_zero); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        int lat;
        logic [W-1:0] x, y, elo, ehi;
        logic edz;
        run_op(SUB, 16'd3, 16'd5, 1'b0, lat);
        n_chk++; if (lat !== 1) $display("FAIL sub_lat: got %0d expected 1", lat); else n_pass++;
        n_chk++; if ({result_hi, result_lo} !== 32'h0001_FFFE)
            $display("FAIL sub_3_5: got %h_%h expected 0001_fffe", result_hi, result_lo); else n_pass++;
        run_op(ADD, 16'hFFFF, 16'd1, 1'b0, lat);
        n_chk++; if ({result_hi, result_lo} !== 32'h0001_0000)
            $display("FAIL add_wrap: got %h_%h expected 0001_0000", result_hi, result_lo); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            x = W'($urandom); y = W'($urandom);
            model((i % 2 == 0) ? ADD : SUB, x, y, 1'b1, elo, ehi, edz);
            run_op((i % 2 == 0) ? ADD : SUB, x, y, 1'b1, lat);
            n_chk++; if (lat !== 1 || {result_hi, result_lo, div_by_zero} !== {ehi, elo, edz})
                $display("FAIL addsub_rand: got lat %0d %h_%h expected lat 1 %h_%h", lat,
                         result_hi, result_lo, ehi, elo); else n_pass++;
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [W-1:0] x, y, elo, ehi;
        logic edz;
        run_op(MUL, 16'd300, 16'd200, 1'b0, lat);
        n_chk++; if (lat !== 17) $display("FAIL mul_lat: got %0d expected 17", lat); else n_pass++;
        n_chk++; if ({result_hi, result_lo} !== 32'h0000_EA60)
            $display("FAIL mul_300_200: got %h_%h expected 0000_ea60", result_hi, result_lo); else n_pass++;
        run_op(MUL, 16'hFFFF, 16'hFFFF, 1'b0, lat);
        n_chk++; if ({result_hi, result_lo} !== 32'hFFFE_0001)
            $display("FAIL mul_max: got %h_%h expected fffe_0001", result_hi, result_lo); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            x = W'($urandom); y = W'($urandom);
            model(MUL, x, y, 1'b0, elo, ehi, edz);
            run_op(MUL, x, y, 1'b0, lat);
            n_chk++; if (lat !== W + 1 || {result_hi, result_lo, div_by_zero} !== {ehi, elo, edz})
                $display("FAIL mul_rand: got lat %0d %h_%h expected lat %0d %h_%h", lat,
                         result_hi, result_lo, W + 1, ehi, elo); else n_pass++;
        end
    endtask

    task automatic test_div();
        int lat;
        logic [W-1:0] x, y, elo, ehi;
        logic edz;
        run_op(DIV, 16'd1000, 16'd7, 1'b0, lat);
        n_chk++; if (lat !== 17) $display("FAIL div_lat: got %0d expected 17", lat); else n_pass++;
        n_chk++; if ({result_hi, result_lo, div_by_zero} !== {16'd6, 16'd142, 1'b0})
            $display("FAIL div_1000_7: got %0d_%0d dbz %b expected 6_142 dbz 0",
                     result_hi, result_lo, div_by_zero); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            x = W'($urandom);
            y = (i < 3) ? W'($urandom_range(1, 20)) : W'($urandom_range(1, 65535));
            model(DIV, x, y, 1'b0, elo, ehi, edz);
            run_op(DIV, x, y, 1'b0, lat);
            n_chk++; if (lat !== W + 1 || {result_hi, result_lo, div_by_zero} !== {ehi, elo, edz})
                $display("FAIL div_rand: got lat %0d %h_%h expected lat %0d %h_%h", lat,
                         result_hi, result_lo, W + 1, ehi, elo); else n_pass++;
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(DIV, 16'd5, 16'd0, 1'b0, lat);
        n_chk++; if (lat !== 1) $display("FAIL dbz_lat: got %0d expected 1", lat); else n_pass++;
        n_chk++; if ({result_hi, result_lo, div_by_zero} !== {16'd5, 16'hFFFF, 1'b1})
            $display("FAIL dbz_5_0: got %h_%h dbz %b expected 0005_ffff dbz 1",
                     result_hi, result_lo, div_by_zero); else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_chk++; if (div_by_zero !== 1'b1 || result_lo !== 16'hFFFF)
            $display("FAIL dbz_hold: got dbz %b lo %h expected dbz 1 lo ffff", div_by_zero, result_lo); else n_pass++;
        run_op(ADD, 16'd2, 16'd3, 1'b0, lat);
        n_chk++; if (div_by_zero !== 1'b0 || result_lo !== 16'd5)
            $display("FAIL dbz_clear: got dbz %b lo %h expected dbz 0 lo 0005", div_by_zero, result_lo); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, seen_done;
        seen_done = 0;
        @(negedge clk);
        op = MUL; a = 16'd1234; b = 16'd567; op_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            if (n < 8) begin #1; if (done) seen_done++; end
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({busy, done, result_lo, result_hi, div_by_zero} !== '0)
            $display("FAIL midrst_outs: got busy %b done %b %h_%h dbz %b expected all 0",
                     busy, done, result_hi, result_lo, div_by_zero); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (done) seen_done++; end
        n_chk++; if (seen_done !== 0) $display("FAIL midrst_nodone: got %0d dones expected 0", seen_done); else n_pass++;
        run_op(MUL, 16'd300, 16'd200, 1'b0, lat);
        n_chk++; if (lat !== 17 || {result_hi, result_lo} !== 32'h0000_EA60)
            $display("FAIL midrst_resume: got lat %0d %h_%h expected lat 17 0000_ea60",
                     lat, result_hi, result_lo); else n_pass++;
    endtask

    task automatic test_start_busy();
        int ndone;
        logic [W-1:0] elo, ehi;
        logic edz, busy_mid;
        ndone = 0; busy_mid = 1'b0;
        model(MUL, 16'd4321, 16'd77, 1'b0, elo, ehi, edz);
        @(negedge clk);
        op = MUL; a = 16'd4321; b = 16'd77; op_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (n == 5) begin busy_mid = busy; start = 1'b1; op = ADD; a = 16'd1; b = 16'd1; end
            if (n == 6) start = 1'b0;
            if (n == W) start = 1'b1;
            if (n == W + 1) start = 1'b0;
        end
        n_chk++; if (busy_mid !== 1'b1) $display("FAIL busy_mid: got %b expected 1", busy_mid); else n_pass++;
        n_chk++; if (ndone !== 1) $display("FAIL busy_one_done: got %0d expected 1", ndone); else n_pass++;
        n_chk++; if ({result_hi, result_lo, busy} !== {ehi, elo, 1'b0})
            $display("FAIL busy_result: got %h_%h busy %b expected %h_%h busy 0",
                     result_hi, result_lo, busy, ehi, elo); else n_pass++;
    endtask

    task automatic test_signed();
        int lat;
        logic [1:0] o;
        logic [W-1:0] x, y, elo, ehi;
        logic edz;
`ifdef SIGNED_EN
        run_op(DIV, 16'hFFF9, 16'd2, 1'b1, lat);
        n_chk++; if ({result_hi, result_lo} !== 32'hFFFF_FFFD)
            $display("FAIL sdiv_m7_2: got %h_%h expected ffff_fffd", result_hi, result_lo); else n_pass++;
        run_op(MUL, 16'hFFFD, 16'd4, 1'b1, lat);
        n_chk++; if ({result_hi, result_lo} !== 32'hFFFF_FFF4)
            $display("FAIL smul_m3_4: got %h_%h expected ffff_fff4", result_hi, result_lo); else n_pass++;
`endif
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom); x = W'($urandom);
            y = (i == 9) ? '0 : W'($urandom);
            model(o, x, y, 1'b1, elo, ehi, edz);
            run_op(o, x, y, 1'b1, lat);
            n_chk++; if (lat !== exp_lat(o, y) || {result_hi, result_lo, div_by_zero} !== {ehi, elo, edz})
                $display("FAIL opsigned_rand: op %0d %h,%h got lat %0d %h_%h dbz %b expected lat %0d %h_%h dbz %b",
                         o, x, y, lat, result_hi, result_lo, div_by_zero, exp_lat(o, y), ehi, elo, edz);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_div_zero();
        test_reset_mid();
        test_start_busy();
        test_signed();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
